cpu_ctrl_sequencer: RTL

Instruction-driven control sequencer sitting directly upstream of the 8-bit CPU datapath: accepts 16-bit instruction words over a valid/ready handshake and generates the datapath's register strobes, ALU controls and immediate-bus drive. Each data-moving instruction runs a fixed SETUP/STROBE sequence so bus drivers settle before any active-low write strobe fires. Also provides zero-flag conditional skip, HALT, illegal-op reporting and a retired-instruction counter.

---
 rtl/cpu_ctrl_sequencer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_sequencer.sv
// cpu_ctrl_sequencer: instruction-driven control sequencer for the 8-bit CPU
// datapath. It accepts 16-bit instruction words over valid/ready and drives
// the register strobes, ALU controls and immediate bus. Each data-moving
// instruction gets a SETUP cycle (bus drivers settle) followed by a STROBE
// cycle (active-low write strobe fires).
//
// Ports:
//   i_clk, i_rstn                     clock, async active-low reset
//   i_instr, i_instr_valid            instruction word and its valid
//   o_instr_ready                     word accepted this cycle when valid
//   i_zr                              ALU zero flag (sampled on SKZ accept)
//   o_a_wrtn/o_a_rdn/o_b_wrtn/o_b_rdn active-low A/B write/read strobes
//   o_alu_opcode, o_cin               ALU operation and carry-in
//   o_alu_sel, o_alu_flag_sel         ALU drives bus / ALU flags update
//   o_bus_data, o_bus_oe              immediate value and its bus enable
//   o_illegal                         one-cycle pulse on undefined class
//   o_halted                          sequencer halted until reset
//   o_instr_cnt                       retired-instruction counter (wraps)
//
// Build option: define CPU_CTRL_COND_SKIP_EN to implement SKZ (class 0x8).
// Without it class 0x8 is illegal and i_zr is ignored.
module cpu_ctrl_sequencer #(
  parameter int unsigned IMM_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [15:0]      i_instr,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic             i_zr,
  output logic             o_a_wrtn,
  output logic             o_a_rdn,
  output logic             o_b_wrtn,
  output logic             o_b_rdn,
  output logic [3:0]       o_alu_opcode,
  output logic             o_cin,
  output logic             o_alu_sel,
  output logic             o_alu_flag_sel,
  output logic [IMM_W-1:0] o_bus_data,
  output logic             o_bus_oe,
  output logic             o_illegal,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] CLS_NOP   = 4'h0;
  localparam logic [3:0] CLS_LDA   = 4'h1;
  localparam logic [3:0] CLS_LDB   = 4'h2;
  localparam logic [3:0] CLS_ALUA  = 4'h3;
  localparam logic [3:0] CLS_ALUB  = 4'h4;
  localparam logic [3:0] CLS_MOVAB = 4'h5;
  localparam logic [3:0] CLS_MOVBA = 4'h6;
  localparam logic [3:0] CLS_HALT  = 4'hF;
`ifdef CPU_CTRL_COND_SKIP_EN
  localparam logic [3:0] CLS_SKZ   = 4'h8;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_SETUP, ST_STROBE, ST_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               retire, illegal_d, discard;

  logic               ready_q, ready_d, halted_q, halted_d, illegal_q;
  logic               a_wrtn_q, a_wrtn_d, a_rdn_q, a_rdn_d;
  logic               b_wrtn_q, b_wrtn_d, b_rdn_q, b_rdn_d;
  logic [3:0]         opcode_q, opcode_d;
  logic               cin_q, cin_d, alu_sel_q, alu_sel_d, flag_q, flag_d;
  logic [IMM_W-1:0]   data_q, data_d;
  logic               oe_q, oe_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         ex_cls;
  logic               in_seq, in_strobe;

`ifdef CPU_CTRL_COND_SKIP_EN
  logic skip_q, skip_d;
  assign discard = skip_q;

  // Skip flag: set by SKZ when the zero flag is high, consumed by next word
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) skip_q <= 1'b0;
    else         skip_q <= skip_d;
  end
`else
  logic unused_zr;
  assign discard   = 1'b0;
  assign unused_zr = i_zr;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, instruction capture, retire and illegal detection
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    retire    = 1'b0;
    illegal_d = 1'b0;
`ifdef CPU_CTRL_COND_SKIP_EN
    skip_d    = skip_q;
`endif
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (i_instr_valid) begin
          if (discard) begin
            // Skipped word: not executed, not counted, never illegal
`ifdef CPU_CTRL_COND_SKIP_EN
            skip_d = 1'b0;
`endif
          end else begin
            instr_d = i_instr;
            case (i_instr[15:12])
              CLS_NOP: retire = 1'b1;
              CLS_LDA, CLS_LDB, CLS_ALUA, CLS_ALUB, CLS_MOVAB, CLS_MOVBA:
                state_d = ST_SETUP;
`ifdef CPU_CTRL_COND_SKIP_EN
              CLS_SKZ: begin
                skip_d = i_zr;
                retire = 1'b1;
              end
`endif
              CLS_HALT: begin
                state_d = ST_HALT;
                retire  = 1'b1;
              end
              default: begin
                illegal_d = 1'b1;
                retire    = 1'b1;
              end
            endcase
          end
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is registered
  always_comb begin
    ex_cls    = instr_d[15:12];
    in_seq    = (state_d == ST_SETUP) || (state_d == ST_STROBE);
    in_strobe = (state_d == ST_STROBE);
    ready_d   = (state_d == ST_FETCH);
    halted_d  = (state_d == ST_HALT);
    a_wrtn_d  = ~(in_strobe && ((ex_cls == CLS_LDA) || (ex_cls == CLS_ALUA) ||
                                (ex_cls == CLS_MOVBA)));
    b_wrtn_d  = ~(in_strobe && ((ex_cls == CLS_LDB) || (ex_cls == CLS_ALUB) ||
                                (ex_cls == CLS_MOVAB)));
    a_rdn_d   = ~(in_seq && (ex_cls == CLS_MOVAB));
    b_rdn_d   = ~(in_seq && (ex_cls == CLS_MOVBA));
    alu_sel_d = in_seq && ((ex_cls == CLS_ALUA) || (ex_cls == CLS_ALUB));
    flag_d    = in_strobe && ((ex_cls == CLS_ALUA) || (ex_cls == CLS_ALUB));
    oe_d      = in_seq && ((ex_cls == CLS_LDA) || (ex_cls == CLS_LDB));
    // Opcode, carry-in and immediate hold their last driven value
    opcode_d  = alu_sel_d ? instr_d[11:8] : opcode_q;
    cin_d     = alu_sel_d ? instr_d[7] : cin_q;
    data_d    = oe_d ? instr_d[IMM_W-1:0] : data_q;
    cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Instruction, counter and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      instr_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      a_wrtn_q  <= 1'b1;
      a_rdn_q   <= 1'b1;
      b_wrtn_q  <= 1'b1;
      b_rdn_q   <= 1'b1;
      opcode_q  <= '0;
      cin_q     <= 1'b0;
      alu_sel_q <= 1'b0;
      flag_q    <= 1'b0;
      data_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      a_wrtn_q  <= a_wrtn_d;
      a_rdn_q   <= a_rdn_d;
      b_wrtn_q  <= b_wrtn_d;
      b_rdn_q   <= b_rdn_d;
      opcode_q  <= opcode_d;
      cin_q     <= cin_d;
      alu_sel_q <= alu_sel_d;
      flag_q    <= flag_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
    end
  end

  assign o_instr_ready  = ready_q;
  assign o_halted       = halted_q;
  assign o_illegal      = illegal_q;
  assign o_a_wrtn       = a_wrtn_q;
  assign o_a_rdn        = a_rdn_q;
  assign o_b_wrtn       = b_wrtn_q;
  assign o_b_rdn        = b_rdn_q;
  assign o_alu_opcode   = opcode_q;
  assign o_cin          = cin_q;
  assign o_alu_sel      = alu_sel_q;
  assign o_alu_flag_sel = flag_q;
  assign o_bus_data     = data_q;
  assign o_bus_oe       = oe_q;
  assign o_instr_cnt    = cnt_q;

endmodule
